// File: rtl/multicycle_ctrl.sv
// Main control FSM for the lab05 multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur, nxt;
    logic   retire;
    logic   set_illegal;

    assign state = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= FETCH;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            cur <= nxt;
            if (retire)
                instr_count <= instr_count + 1'b1;
            if (set_illegal)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt         = FETCH;
        retire      = 1'b0;
        set_illegal = 1'b0;
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl    = ALU_ADD;
        pc_src      = 2'b00;
        unique case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                nxt       = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        nxt         = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                nxt      = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                nxt       = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                nxt       = ALUWB;
                case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default: begin
                        set_illegal = 1'b1;
                        nxt         = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
                retire    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected values are queued when
// stimulus is driven and popped as the FSM produces each state.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          mem_ready;
    logic          pc_en;
    logic          iord;
    logic          mem_read;
    logic          mem_write;
    logic          ir_write;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          reg_write;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_ctrl;
    logic [1:0]    pc_src;
    logic [3:0]    state;
    logic          illegal;
    logic [CW-1:0] instr_count;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .state(state), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed %0h required an entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input string tag, input logic [3:0] st);
        push(tag, 32'(st));
        tick();
        pop_chk(32'(state));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] v);
        push(tag, v);
        pop_chk(obs);
    endtask

    initial begin
        rst       = 1'b1;
        op        = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(instr_count), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_mem_read", 32'(mem_read), 1);
        chk("rst_pc_en", 32'(pc_en), 1);
        chk("rst_alu_src_b", 32'(alu_src_b), 1);
        rst = 1'b0;

        // T1: lw
        op = 6'b100011;
        chk("lw_ir_write", 32'(ir_write), 1);
        step("lw_s1", 1);
        chk("lw_rw1", 32'(reg_write), 0);
        step("lw_s2", 2);
        chk("lw_srcb", 32'(alu_src_b), 2);
        step("lw_s3", 3);
        chk("lw_iord", 32'(iord), 1);
        chk("lw_rw3", 32'(reg_write), 0);
        step("lw_s4", 4);
        chk("lw_rw4", 32'(reg_write), 1);
        chk("lw_m2r", 32'(mem_to_reg), 1);
        step("lw_s0", 0);
        chk("lw_rw0", 32'(reg_write), 0);
        chk("lw_count", 32'(instr_count), 1);

        // T2: R add then sub
        op = 6'b000000;
        funct = 6'b100000;
        step("add_s1", 1);
        step("add_s6", 6);
        chk("add_alu", 32'(alu_ctrl), 3'b010);
        step("add_s7", 7);
        chk("add_regdst", 32'(reg_dst), 1);
        chk("add_rw", 32'(reg_write), 1);
        step("add_s0", 0);
        funct = 6'b100010;
        step("sub_s1", 1);
        step("sub_s6", 6);
        chk("sub_alu", 32'(alu_ctrl), 3'b110);
        step("sub_s7", 7);
        step("sub_s0", 0);
        chk("r_count", 32'(instr_count), 3);

        // T3: beq taken then not taken
        op = 6'b000100;
        zero = 1'b1;
        step("beq1_s1", 1);
        step("beq1_s8", 8);
        chk("beq1_pc_en", 32'(pc_en), 1);
        chk("beq1_pc_src", 32'(pc_src), 1);
        chk("beq1_alu", 32'(alu_ctrl), 3'b110);
        step("beq1_s0", 0);
        zero = 1'b0;
        step("beq0_s1", 1);
        step("beq0_s8", 8);
        chk("beq0_pc_en", 32'(pc_en), 0);
        step("beq0_s0", 0);
        chk("beq_count", 32'(instr_count), 5);

        // T4: sw with memory stalled three cycles
        op = 6'b101011;
        step("sw_s1", 1);
        step("sw_s2", 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("sw_wait_s5", 5);
            chk("sw_wait_mw", 32'(mem_write), 1);
            chk("sw_wait_count", 32'(instr_count), 5);
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_ready_mw", 32'(mem_write), 1);
        chk("sw_ready_iord", 32'(iord), 1);
        step("sw_s0", 0);
        chk("sw_mw_off", 32'(mem_write), 0);
        chk("sw_count", 32'(instr_count), 6);

        // T5: illegal op, bad funct, then valid addi and j
        op = 6'b111111;
        step("ill_s1", 1);
        chk("ill_pre", 32'(illegal), 0);
        step("ill_s0", 0);
        chk("ill_set", 32'(illegal), 1);
        chk("ill_count", 32'(instr_count), 6);
        op = 6'b000000;
        funct = 6'b111111;
        step("badf_s1", 1);
        step("badf_s6", 6);
        step("badf_s0", 0);
        chk("badf_count", 32'(instr_count), 6);
        op = 6'b001000;
        step("addi_s1", 1);
        step("addi_s9", 9);
        chk("addi_srcb", 32'(alu_src_b), 2);
        step("addi_s10", 10);
        chk("addi_rw", 32'(reg_write), 1);
        chk("addi_regdst", 32'(reg_dst), 0);
        step("addi_s0", 0);
        chk("addi_count", 32'(instr_count), 7);
        op = 6'b000010;
        step("j_s1", 1);
        step("j_s11", 11);
        chk("j_pc_en", 32'(pc_en), 1);
        chk("j_pc_src", 32'(pc_src), 2);
        step("j_s0", 0);
        chk("j_count", 32'(instr_count), 8);
        chk("ill_sticky", 32'(illegal), 1);

        // Counter wrap: 8 more jumps take a 4-bit count from 8 to 0
        for (int i = 0; i < 8; i++) begin
            step("wrap_s1", 1);
            step("wrap_s11", 11);
            step("wrap_s0", 0);
        end
        chk("wrap_count", 32'(instr_count), 0);

        // T6: async reset in MEMRD
        op = 6'b100011;
        step("ab_s1", 1);
        step("ab_s2", 2);
        step("ab_s3", 3);
        #1;
        rst = 1'b1;
        #1;
        chk("ab_state", 32'(state), 0);
        chk("ab_count", 32'(instr_count), 0);
        chk("ab_illegal", 32'(illegal), 0);
        chk("ab_rw", 32'(reg_write), 0);
        tick();
        chk("ab_hold", 32'(state), 0);
        rst = 1'b0;
        op = 6'b000010;
        step("post_s1", 1);
        step("post_s11", 11);
        step("post_s0", 0);
        chk("post_count", 32'(instr_count), 1);

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0",
                     q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
